// File: rtl/peso_banco.sv
// Weight bank and update sequencer for one perceptron neuron, closing the att_peso loop.
// Optional PESO_SKIP_ZERO_ERR_EN: a pass whose d equals y goes straight to FIN.
module peso_banco #(
  parameter int N_IN  = 4,
  parameter int TAM   = 16,
  parameter int IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [TAM-1:0]      d,
  input  logic [TAM-1:0]      y,
  input  logic [N_IN*TAM-1:0] in_vec,
  input  logic                ld_en,
  input  logic [IDX_W-1:0]    ld_idx,
  input  logic [TAM-1:0]      ld_data,
  input  logic [TAM-1:0]      w_out,
  output logic                en_att,
  output logic [TAM-1:0]      w_in,
  output logic [TAM-1:0]      in_sel,
  output logic [TAM-1:0]      d_q,
  output logic [TAM-1:0]      y_q,
  output logic                busy,
  output logic                done,
  output logic [N_IN*TAM-1:0] weights
);

  // state | meaning
  // IDLE  | waiting for start, direct weight loads allowed
  // ISSUE | present weights[idx] and sample[idx] to att_peso
  // WRITE | capture w_out into weights[idx], advance or finish
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, ISSUE, WRITE, FIN} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);

  state_t           state;
  logic [TAM-1:0]   wbank [N_IN];
  logic [TAM-1:0]   samp  [N_IN];
  logic [IDX_W-1:0] idx;
  logic             skip_pass;
  logic             ld_ok;

`ifdef PESO_SKIP_ZERO_ERR_EN
  assign skip_pass = (d == y);
`else
  assign skip_pass = 1'b0;
`endif

  assign ld_ok = ld_en && (int'(ld_idx) < N_IN);

  // Operand muxes read registers only, so the loaded value is used on the first ISSUE.
  assign w_in   = wbank[idx];
  assign in_sel = samp[idx];

  for (genvar g = 0; g < N_IN; g++) begin : g_flat
    assign weights[g*TAM +: TAM] = wbank[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      en_att <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d_q    <= '0;
      y_q    <= '0;
      for (int i = 0; i < N_IN; i++) begin
        wbank[i] <= '0;
        samp[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (ld_ok) wbank[ld_idx] <= ld_data;
          if (start) begin
            d_q <= d;
            y_q <= y;
            for (int i = 0; i < N_IN; i++) samp[i] <= in_vec[i*TAM +: TAM];
            idx <= '0;
            if (skip_pass) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state  <= ISSUE;
              en_att <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        ISSUE: state <= WRITE;
        WRITE: begin
          wbank[idx] <= w_out;
          if (idx == LAST) begin
            state  <= FIN;
            en_att <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= ISSUE;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
